// File: rtl/led_cmd_pkg.sv
// Shared constants, types and helpers for the LED command controller.
package led_cmd_pkg;

  // ASCII bytes recognised by the command parser
  localparam logic [7:0] AsciiO    = 8'h4F;
  localparam logic [7:0] AsciiF    = 8'h46;
  localparam logic [7:0] AsciiB    = 8'h42;
  localparam logic [7:0] AsciiP    = 8'h50;
  localparam logic [7:0] AsciiStar = 8'h2A;
  localparam logic [7:0] Ascii0    = 8'h30;
  localparam logic [7:0] AsciiCr   = 8'h0D;
  localparam logic [7:0] AsciiLf   = 8'h0A;
  localparam logic [7:0] AsciiSp   = 8'h20;

  // Per-channel drive mode
  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeBlink = 2'd2,
    ModePwm   = 2'd3
  } mode_e;

  // Parser FSM states, kept as plain constants for legacy tools
  typedef logic [1:0] state_t;
  localparam state_t StIdle   = 2'd0;
  localparam state_t StGetCh  = 2'd1;
  localparam state_t StGetLvl = 2'd2;

  // Mode selected by a single-argument opcode (O/F/B)
  function automatic mode_e opc_to_mode(input logic [7:0] opc);
    mode_e m;
    m = ModeOff;
    if (opc == AsciiO) m = ModeOn;
    else if (opc == AsciiB) m = ModeBlink;
    return m;
  endfunction

endpackage

// File: rtl/led_cmd_ctrl_if.sv
// Byte-stream input and command status pulses between uart_rx side and the controller.
interface led_cmd_ctrl_if;
  logic [7:0] data;
  logic       data_valid;
  logic       cmd_done;
  logic       cmd_err;

  modport master (output data, output data_valid, input cmd_done, input cmd_err);
  modport slave  (input data, input data_valid, output cmd_done, output cmd_err);
endinterface

// File: rtl/led_pwm_gen.sv
// Shared PWM and blink timebase plus per-channel mode/level to LED mux.
module led_pwm_gen
  import led_cmd_pkg::*;
#(
  parameter int unsigned NUM_LEDS   = 4,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned BLINK_HALF = 6000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  mode_e [NUM_LEDS-1:0]               mode_i,
  input  logic  [NUM_LEDS-1:0][PWM_BITS-1:0] level_i,
  output logic  [NUM_LEDS-1:0]               led_o
);

  localparam int unsigned BlinkW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [BlinkW-1:0]   blink_cnt_q;
  logic                blink_phase_q;
  logic [NUM_LEDS-1:0] led_d, led_q;

  // Per-channel LED value from the current mode and shared timebase
  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      unique case (mode_i[i])
        ModeOff:   led_d[i] = 1'b0;
        ModeOn:    led_d[i] = 1'b1;
        ModeBlink: led_d[i] = blink_phase_q;
        ModePwm:   led_d[i] = (pwm_cnt_q < level_i[i]);
        default:   led_d[i] = 1'b0;
      endcase
    end
  end

  // Free-running PWM counter, blink half-period counter and registered LED drive
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      led_q         <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_cmd_ctrl.sv
// Multi-channel LED controller driven by ASCII commands from a UART byte stream.
module led_cmd_ctrl
  import led_cmd_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = 4,
  parameter int unsigned PWM_BITS       = 4,
  parameter int unsigned BLINK_HALF     = 6000000,
  parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
  input  logic                clk,
  input  logic                rst,
  led_cmd_ctrl_if.slave       cmd_if,
  output logic [NUM_LEDS-1:0] led
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  state_t                             state_q, state_d;
  logic [7:0]                         opc_q, opc_d;
  logic [NUM_LEDS-1:0]                mask_q, mask_d;
  mode_e [NUM_LEDS-1:0]               mode_q, mode_d;
  logic  [NUM_LEDS-1:0][PWM_BITS-1:0] level_q, level_d;
  logic [TmoW-1:0]                    tmo_q, tmo_d;
  logic                               done_q, done_d;
  logic                               err_q, err_d;

  logic                ch_valid;
  logic [NUM_LEDS-1:0] ch_mask;
  logic                is_opc;
  logic                is_ws;
  logic                tmo_hit;

  // Decode the current byte as a channel selector ('*' or a digit below NUM_LEDS)
  always_comb begin
    ch_mask = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      ch_mask[i] = (cmd_if.data == AsciiStar) || (cmd_if.data == Ascii0 + 8'(i));
    end
    ch_valid = |ch_mask;
  end

  assign is_opc = (cmd_if.data == AsciiO) || (cmd_if.data == AsciiF) ||
                  (cmd_if.data == AsciiB) || (cmd_if.data == AsciiP);
  assign is_ws  = (cmd_if.data == AsciiCr) || (cmd_if.data == AsciiLf) ||
                  (cmd_if.data == AsciiSp);
  // An arriving byte always beats expiry in the same cycle
  assign tmo_hit = (state_q != StIdle) && (tmo_q == TmoLast) && !cmd_if.data_valid;

  // Parser next state, channel register updates, timeout and status pulses
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    level_d = level_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tmo_d   = (state_q == StIdle) ? '0 : tmo_q + 1'b1;

    if (cmd_if.data_valid) begin
      tmo_d = '0;
      unique case (state_q)
        StIdle: begin
          if (is_opc) begin
            opc_d   = cmd_if.data;
            state_d = StGetCh;
          end else if (!is_ws) begin
            err_d = 1'b1;
          end
        end
        StGetCh: begin
          state_d = StIdle;
          if (!ch_valid) begin
            err_d = 1'b1;
          end else if (opc_q == AsciiP) begin
            mask_d  = ch_mask;
            state_d = StGetLvl;
          end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
              if (ch_mask[i]) mode_d[i] = opc_to_mode(opc_q);
            end
            done_d = 1'b1;
          end
        end
        StGetLvl: begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            if (mask_q[i]) begin
              mode_d[i]  = ModePwm;
              level_d[i] = cmd_if.data[7 -: PWM_BITS];
            end
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (tmo_hit) begin
      err_d   = 1'b1;
      state_d = StIdle;
      tmo_d   = '0;
    end
  end

  // Parser and channel configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      opc_q   <= '0;
      mask_q  <= '0;
      level_q <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) mode_q[i] <= ModeOff;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      level_q <= level_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_if.cmd_done = done_q;
  assign cmd_if.cmd_err  = err_q;

  led_pwm_gen #(
    .NUM_LEDS  (NUM_LEDS),
    .PWM_BITS  (PWM_BITS),
    .BLINK_HALF(BLINK_HALF)
  ) u_pwm_gen (
    .clk    (clk),
    .rst    (rst),
    .mode_i (mode_q),
    .level_i(level_q),
    .led_o  (led)
  );

endmodule
